// File: rtl/instruction_fetch_param.sv
// Instruction fetch stage: PC register, branch/jump/sequential next-PC
// selection and a 2-entry fetch buffer between a 1-cycle-latency
// synchronous instruction memory and a back-pressuring IF/ID register.
//
// Handshake: the head entry is offered with instr_valid and leaves the
// buffer in a cycle where instr_valid & id_ready & enable & !redirect.
// instr_valid depends only on stored state and reset, never on id_ready,
// and the head is stable until it transfers or a redirect flushes it.
module instruction_fetch_param #(
  parameter int                     PC_WIDTH       = 6,
  parameter int                     MEM_ADDR_WIDTH = 10,
  parameter int                     INSTR_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC       = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      branch_taken,
  input  logic [PC_WIDTH-1:0]       branch_address,
  input  logic                      jump_taken,
  input  logic [PC_WIDTH-1:0]       jump_address,
  output logic                      imem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]    imem_data,
  output logic [INSTR_WIDTH-1:0]    instr_out,
  output logic [PC_WIDTH-1:0]       pc_out,
  output logic                      instr_valid,
  input  logic                      id_ready
);

  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [1:0]             count_q, count_d;
  logic                   inflight_q;
  logic [PC_WIDTH-1:0]    inflight_pc_q;
  logic [INSTR_WIDTH-1:0] buf_instr_q [2];
  logic [INSTR_WIDTH-1:0] buf_instr_d [2];
  logic [PC_WIDTH-1:0]    buf_pc_q    [2];
  logic [PC_WIDTH-1:0]    buf_pc_d    [2];

  logic                   redirect;
  logic                   pop;
  logic                   capture;
  logic                   rd_en;
  logic [2:0]             occupancy;
  logic [PC_WIDTH-1:0]    issue_addr;

  // A redirect is only honoured while the stage is enabled.
  assign redirect    = enable & (branch_taken | jump_taken);
  assign instr_valid = (count_q != 2'd0) & ~reset;
  assign pop         = instr_valid & id_ready & enable & ~redirect;

  // Buffered entries plus the outstanding read: a slot is always reserved
  // for data already in flight, so the buffer can never overflow.
  assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
  assign rd_en       = enable & ~reset & ((occupancy < 3'd2) | pop | redirect);

  // Branch beats jump, jump beats sequential.
  assign issue_addr  = branch_taken ? branch_address :
                       jump_taken   ? jump_address   : fetch_pc_q;

  // Returning data is dropped when a redirect makes it stale.
  assign capture     = inflight_q & ~redirect;

  assign imem_rd_en  = rd_en;
  assign imem_addr   = MEM_ADDR_WIDTH'(issue_addr);
  assign instr_out   = instr_valid ? buf_instr_q[0] : NOP_INSTR;
  assign pc_out      = instr_valid ? buf_pc_q[0]    : '0;
  assign fetch_pc_d  = rd_en ? issue_addr + 1'b1 : fetch_pc_q;

  // Next buffer contents: entry 0 is always the head; pop shifts, capture appends.
  always_comb begin
    count_d        = count_q;
    buf_instr_d[0] = buf_instr_q[0];
    buf_instr_d[1] = buf_instr_q[1];
    buf_pc_d[0]    = buf_pc_q[0];
    buf_pc_d[1]    = buf_pc_q[1];
    if (redirect) begin
      count_d = 2'd0;
    end else if (pop && capture) begin
      if (count_q == 2'd1) begin
        buf_instr_d[0] = imem_data;
        buf_pc_d[0]    = inflight_pc_q;
      end else begin
        buf_instr_d[0] = buf_instr_q[1];
        buf_pc_d[0]    = buf_pc_q[1];
        buf_instr_d[1] = imem_data;
        buf_pc_d[1]    = inflight_pc_q;
      end
    end else if (pop) begin
      buf_instr_d[0] = buf_instr_q[1];
      buf_pc_d[0]    = buf_pc_q[1];
      count_d        = count_q - 2'd1;
    end else if (capture) begin
      buf_instr_d[count_q[0]] = imem_data;
      buf_pc_d[count_q[0]]    = inflight_pc_q;
      count_d                 = count_q + 2'd1;
    end
  end

  // Control state: PC, occupancy and the in-flight tag; reset wins over all.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
      if (rd_en) inflight_pc_q <= issue_addr;
    end
  end

  // Buffer payload storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clock) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

endmodule

// File: tb/tb_instruction_fetch_param.sv
// Bench for instruction_fetch_param: directed scenarios plus a randomized
// run, with an in-order delivery scoreboard driven by a program-order model.
module tb_instruction_fetch_param;

  localparam int              PW     = 6;
  localparam int              AW     = 10;
  localparam int              IW     = 32;
  localparam logic [PW-1:0]   RST_PC = 6'd4;
  localparam logic [IW-1:0]   NOP    = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_address = '0;
  logic          jump_taken = 1'b0;
  logic [PW-1:0] jump_address = '0;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data = '0;
  logic [IW-1:0] instr_out;
  logic [PW-1:0] pc_out;
  logic          instr_valid;
  logic          id_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  instruction_fetch_param #(
    .PC_WIDTH(PW), .MEM_ADDR_WIDTH(AW), .INSTR_WIDTH(IW),
    .RESET_PC(RST_PC), .NOP_INSTR(NOP)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .jump_taken(jump_taken), .jump_address(jump_address),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .id_ready(id_ready)
  );

  // clock / reset block
  always #5 clock = ~clock;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 6'h2a, ~a, 6'h15};
  endfunction

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clock) if (imem_rd_en) imem_data <= mem_word(imem_addr);

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: the stage must deliver PCs in program order starting at the
  // reset vector, jumping to the winning redirect target.
  logic          mon_on = 1'b0;
  logic [PW-1:0] exp_pc = RST_PC;
  always @(negedge clock) begin
    if (mon_on) begin
      if (reset) begin
        exp_pc = RST_PC;
      end else if (enable && (branch_taken || jump_taken)) begin
        exp_pc = branch_taken ? branch_address : jump_address;
      end else if (enable && id_ready && instr_valid) begin
        total++;
        if (pc_out !== exp_pc) begin
          bad++;
          $display("FAIL xfer_pc got=%0d want=%0d", pc_out, exp_pc);
        end
        total++;
        if (instr_out !== mem_word(AW'(exp_pc))) begin
          bad++;
          $display("FAIL xfer_instr got=%h want=%h", instr_out, mem_word(AW'(exp_pc)));
        end
        exp_pc = exp_pc + 1'b1;
      end
      if (!instr_valid) begin
        total++;
        if (instr_out !== NOP) begin
          bad++;
          $display("FAIL empty_nop got=%h want=%h", instr_out, NOP);
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; id_ready = 1'b1;
    branch_taken = 1'b0; jump_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total++;
      if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", imem_rd_en); end
      total++;
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
      total++;
      if (pc_out !== '0) begin bad++; $display("FAIL reset_pc got=%0d want=0", pc_out); end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_stream;
    logic [PW-1:0] e;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      e = RST_PC + PW'(c);
      total++;
      if (imem_rd_en !== 1'b1 || imem_addr !== AW'(e)) begin
        bad++; $display("FAIL stream_addr c=%0d got=%0d/%b want=%0d/1", c, imem_addr, imem_rd_en, e);
      end
      total++;
      if (instr_valid !== (c >= 2)) begin
        bad++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, instr_valid, c >= 2);
      end
      if (c >= 2) begin
        e = RST_PC + PW'(c) - 6'd2;
        total++;
        if (pc_out !== e) begin bad++; $display("FAIL stream_pc c=%0d got=%0d want=%0d", c, pc_out, e); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] h;
    h = RST_PC + 6'd4;
    id_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== h || instr_out !== mem_word(AW'(h))) begin
        bad++; $display("FAIL stall_hold s=%0d got=%b/%0d want=1/%0d", s, instr_valid, pc_out, h);
      end
      total++;
      if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL stall_rd_en s=%0d got=%b want=0", s, imem_rd_en); end
      tick();
    end
    id_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clock);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== h + PW'(r)) begin
        bad++; $display("FAIL release_pc r=%0d got=%b/%0d want=1/%0d", r, instr_valid, pc_out, h + PW'(r));
      end
      tick();
    end
  endtask

  task automatic test_redirect;
    branch_taken = 1'b1; branch_address = 6'd20;
    jump_taken = 1'b1; jump_address = 6'd40;
    @(negedge clock);
    total++;
    if (imem_rd_en !== 1'b1 || imem_addr !== AW'(20)) begin
      bad++; $display("FAIL redirect_addr got=%0d/%b want=20/1", imem_addr, imem_rd_en);
    end
    tick();
    branch_taken = 1'b0; jump_taken = 1'b0;
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL redirect_flush got=%b want=0", instr_valid); end
    tick();
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b1 || pc_out !== 6'd20) begin
      bad++; $display("FAIL redirect_target got=%b/%0d want=1/20", instr_valid, pc_out);
    end
    tick();
    @(negedge clock);
    total++;
    if (pc_out !== 6'd21) begin bad++; $display("FAIL redirect_next got=%0d want=21", pc_out); end
    tick();
  endtask

  task automatic test_wrap;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] pc_q[$];
    logic [PW-1:0] w;
    exp_q = {6'd62, 6'd63, 6'd0, 6'd1};
    pc_q  = {6'd62, 6'd63, 6'd0, 6'd1};
    jump_taken = 1'b1; jump_address = 6'd62;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) jump_taken = 1'b0;
      @(negedge clock);
      if (i < 4) begin
        w = exp_q.pop_front();
        total++;
        if (imem_addr !== AW'(w)) begin bad++; $display("FAIL wrap_addr i=%0d got=%0d want=%0d", i, imem_addr, w); end
      end
      if (i >= 2) begin
        w = pc_q.pop_front();
        total++;
        if (pc_out !== w) begin bad++; $display("FAIL wrap_pc i=%0d got=%0d want=%0d", i, pc_out, w); end
      end
      tick();
    end
  endtask

  task automatic test_enable;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total++;
      if (pc_out !== 6'd2 + PW'(k)) begin bad++; $display("FAIL en_pre k=%0d got=%0d want=%0d", k, pc_out, 6'd2 + PW'(k)); end
      tick();
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total++;
      if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL en_off_rd k=%0d got=%b want=0", k, imem_rd_en); end
      total++;
      if (instr_valid !== 1'b1 || pc_out !== 6'd5 || instr_out !== mem_word(AW'(5))) begin
        bad++; $display("FAIL en_off_hold k=%0d got=%b/%0d want=1/5", k, instr_valid, pc_out);
      end
      tick();
    end
    enable = 1'b1;
    @(negedge clock);
    total++;
    if (imem_rd_en !== 1'b1 || imem_addr !== AW'(7)) begin
      bad++; $display("FAIL en_resume got=%0d/%b want=7/1", imem_addr, imem_rd_en);
    end
    tick();
    @(negedge clock);
    total++;
    if (pc_out !== 6'd6) begin bad++; $display("FAIL en_next got=%0d want=6", pc_out); end
    tick();
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
      bad++; $display("FAIL rmid_cycle got=%b/%b want=0/0", instr_valid, imem_rd_en);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== AW'(RST_PC)) begin
      bad++; $display("FAIL rmid_restart got=%b/%b/%0d want=0/1/%0d", instr_valid, imem_rd_en, imem_addr, RST_PC);
    end
    tick();
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b want=0", instr_valid); end
    tick();
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b1 || pc_out !== RST_PC) begin
      bad++; $display("FAIL rmid_first got=%b/%0d want=1/%0d", instr_valid, pc_out, RST_PC);
    end
    tick();
  endtask

  task automatic test_random;
    logic          have_prev, prev_hold;
    logic [PW-1:0] prev_pc, tgt;
    logic [IW-1:0] prev_ins;
    int            r;
    have_prev = 1'b0; prev_hold = 1'b0; prev_pc = '0; prev_ins = '0;
    for (int n = 0; n < 400; n++) begin
      enable         = ($urandom_range(0, 9) != 0);
      id_ready       = ($urandom_range(0, 9) < 6);
      r              = $urandom_range(0, 19);
      branch_taken   = (r == 0) || (r == 2);
      jump_taken     = (r == 1) || (r == 2);
      branch_address = PW'($urandom);
      jump_address   = PW'($urandom);
      @(negedge clock);
      if (!enable) begin
        total++;
        if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL rnd_off_rd n=%0d got=%b want=0", n, imem_rd_en); end
      end else if (branch_taken || jump_taken) begin
        tgt = branch_taken ? branch_address : jump_address;
        total++;
        if (imem_rd_en !== 1'b1 || imem_addr !== AW'(tgt)) begin
          bad++; $display("FAIL rnd_redir n=%0d got=%0d/%b want=%0d/1", n, imem_addr, imem_rd_en, tgt);
        end
      end
      if (have_prev && prev_hold) begin
        total++;
        if (instr_valid !== 1'b1 || pc_out !== prev_pc || instr_out !== prev_ins) begin
          bad++; $display("FAIL rnd_stable n=%0d got=%b/%0d want=1/%0d", n, instr_valid, pc_out, prev_pc);
        end
      end
      have_prev = 1'b1;
      prev_hold = instr_valid && !(enable && (branch_taken || jump_taken)) &&
                  !(enable && id_ready);
      prev_pc   = pc_out;
      prev_ins  = instr_out;
      tick();
    end
    enable = 1'b1; id_ready = 1'b1; branch_taken = 1'b0; jump_taken = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    total++;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL rnd_drain got=%b want=1", instr_valid); end
    tick();
  endtask

  initial begin
    mon_on = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
